// File: rtl/csi2_vc_demux.sv
// CSI-2 packet demultiplexer: parses packet headers, tracks frame starts per
// virtual channel and routes long-packet payload to per-VC AXI4-stream outputs.
//
// state     | meaning
// S_HDR     | waiting for a packet header word
// S_PAYLOAD | forwarding payload words of a long packet to its VC output
// S_TAIL    | discarding CRC-only words up to the end of the packet
// S_DISCARD | dropping a long packet addressed to a VC without an output
`timescale 1ns/1ps
module csi2_vc_demux #(
   parameter int VC_AMOUNT = 4,
   parameter int STRIP_CRC = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [31:0]                pkt_tdata_i,
   input  logic                       pkt_tvalid_i,
   input  logic                       pkt_tlast_i,
   output logic                       pkt_tready_o,
   output logic [VC_AMOUNT-1:0][31:0] vc_tdata_o,
   output logic [VC_AMOUNT-1:0][3:0]  vc_tstrb_o,
   output logic [VC_AMOUNT-1:0]       vc_tvalid_o,
   output logic [VC_AMOUNT-1:0]       vc_tlast_o,
   output logic [VC_AMOUNT-1:0]       vc_tuser_o,
   input  logic [VC_AMOUNT-1:0]       vc_tready_i,
   output logic                       len_err_o,
   output logic                       drop_o
);
   typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_TAIL, S_DISCARD} state_t;

   state_t               state_q, state_d;
   logic [1:0]           vc_q, vc_d;
   logic [16:0]          rem_q, rem_d;
   logic                 tail_ok_q, tail_ok_d;
   logic                 tail_err_q, tail_err_d;
   logic [VC_AMOUNT-1:0] sof_pend_q, sof_pend_d;
   logic                 len_err_q, len_err_d;
   logic                 drop_q, drop_d;

   logic [VC_AMOUNT-1:0][31:0] data_q;
   logic [VC_AMOUNT-1:0][3:0]  strb_q;
   logic [VC_AMOUNT-1:0]       valid_q, last_q, user_q;
   logic [VC_AMOUNT-1:0]       load;
   logic [3:0]                 strb_new;
   logic                       last_new, user_new;

   logic        sel_valid, sel_ready, hs;
   logic [1:0]  hdr_vc;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic [16:0] hdr_rem, rem_step, rem_next;
   logic        hdr_in_range, hdr_tail_ok;

   assign hdr_vc       = pkt_tdata_i[7:6];
   assign hdr_dt       = pkt_tdata_i[5:0];
   assign hdr_wc       = pkt_tdata_i[23:8];
   assign hdr_rem      = (STRIP_CRC != 0) ? {1'b0, hdr_wc} : {1'b0, hdr_wc} + 17'd2;
   assign hdr_in_range = ({30'd0, hdr_vc} < 32'(VC_AMOUNT));
   // With CRC stripped, the two CRC bytes spill into a word of their own when WC mod 4 is 0 or 3.
   assign hdr_tail_ok  = (STRIP_CRC != 0) && ((hdr_wc[1:0] == 2'd0) || (hdr_wc[1:0] == 2'd3));

   assign rem_step = (rem_q >= 17'd4) ? 17'd4 : rem_q;
   assign rem_next = rem_q - rem_step;
   assign strb_new = (rem_q >= 17'd4) ? 4'hF : 4'((5'd1 << rem_q[1:0]) - 5'd1);

   always_comb begin
      sel_valid = 1'b0;
      sel_ready = 1'b0;
      for (int v = 0; v < VC_AMOUNT; v++) begin
         if (vc_q == 2'(v)) begin
            sel_valid = valid_q[v];
            sel_ready = vc_tready_i[v];
         end
      end
   end

   assign pkt_tready_o = (state_q == S_PAYLOAD) ? (!sel_valid || sel_ready) : 1'b1;
   assign hs           = pkt_tvalid_i && pkt_tready_o;

   always_comb begin
      state_d    = state_q;
      vc_d       = vc_q;
      rem_d      = rem_q;
      tail_ok_d  = tail_ok_q;
      tail_err_d = tail_err_q;
      sof_pend_d = sof_pend_q;
      len_err_d  = 1'b0;
      drop_d     = 1'b0;
      load       = '0;
      last_new   = 1'b0;
      user_new   = 1'b0;
      case (state_q)
         S_HDR: begin
            if (hs) begin
               vc_d       = hdr_vc;
               rem_d      = hdr_rem;
               tail_ok_d  = hdr_tail_ok;
               tail_err_d = 1'b0;
               if (hdr_dt < 6'h10) begin
                  for (int v = 0; v < VC_AMOUNT; v++) begin
                     if (hdr_vc == 2'(v)) begin
                        if (hdr_dt == 6'h00) sof_pend_d[v] = 1'b1;
                        else if (hdr_dt == 6'h01) sof_pend_d[v] = 1'b0;
                     end
                  end
               end else if (pkt_tlast_i) begin
                  len_err_d = 1'b1;
               end else if (!hdr_in_range) begin
                  drop_d  = 1'b1;
                  state_d = S_DISCARD;
               end else if (hdr_rem == 17'd0) begin
                  state_d = S_TAIL;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (hs) begin
               for (int v = 0; v < VC_AMOUNT; v++) begin
                  if (vc_q == 2'(v)) begin
                     load[v]       = 1'b1;
                     user_new      = sof_pend_q[v];
                     sof_pend_d[v] = 1'b0;
                  end
               end
               rem_d = rem_next;
               if (pkt_tlast_i && (rem_q > 17'd4)) begin
                  last_new  = 1'b1;
                  len_err_d = 1'b1;
                  state_d   = S_HDR;
               end else if (rem_next == 17'd0) begin
                  last_new = 1'b1;
                  state_d  = pkt_tlast_i ? S_HDR : S_TAIL;
               end
            end
         end
         S_TAIL: begin
            if (hs) begin
               if (tail_ok_q) begin
                  tail_ok_d = 1'b0;
               end else if (!tail_err_q) begin
                  len_err_d  = 1'b1;
                  tail_err_d = 1'b1;
               end
               if (pkt_tlast_i) state_d = S_HDR;
            end
         end
         default: begin
            if (hs && pkt_tlast_i) state_d = S_HDR;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_HDR;
         vc_q       <= '0;
         rem_q      <= '0;
         tail_ok_q  <= 1'b0;
         tail_err_q <= 1'b0;
         sof_pend_q <= '0;
         len_err_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vc_q       <= vc_d;
         rem_q      <= rem_d;
         tail_ok_q  <= tail_ok_d;
         tail_err_q <= tail_err_d;
         sof_pend_q <= sof_pend_d;
         len_err_q  <= len_err_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q  <= '0;
         strb_q  <= '0;
         valid_q <= '0;
         last_q  <= '0;
         user_q  <= '0;
      end else begin
         for (int v = 0; v < VC_AMOUNT; v++) begin
            if (load[v]) begin
               data_q[v]  <= pkt_tdata_i;
               strb_q[v]  <= strb_new;
               valid_q[v] <= 1'b1;
               last_q[v]  <= last_new;
               user_q[v]  <= user_new;
            end else if (vc_tready_i[v]) begin
               valid_q[v] <= 1'b0;
            end
         end
      end
   end

   assign vc_tdata_o  = data_q;
   assign vc_tstrb_o  = strb_q;
   assign vc_tvalid_o = valid_q;
   assign vc_tlast_o  = last_q;
   assign vc_tuser_o  = user_q;
   assign len_err_o   = len_err_q;
   assign drop_o      = drop_q;

endmodule

// File: tb/tb_csi2_vc_demux.sv
// Bench for csi2_vc_demux: two instances (4 VCs with CRC strip, 2 VCs forwarding
// CRC) checked against a byte-count packet model and per-VC scoreboards.
`timescale 1ns/1ps
module tb_csi2_vc_demux;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][31:0] in_data  = '0;
   logic [1:0]       in_valid = '0;
   logic [1:0]       in_last  = '0;
   wire  [1:0]       in_ready;
   wire  [1:0][3:0][31:0] o_data;
   wire  [1:0][3:0][3:0]  o_strb;
   wire  [1:0][3:0]       o_valid, o_last, o_user;
   wire  [1:0]            o_err, o_drop;
   logic [1:0][3:0]       rdy = '1;
   logic [1:0][3:0]       rdy_force = '1;
   int                    rdy_mode = 0;

   assign o_data[1][3:2]  = '0;
   assign o_strb[1][3:2]  = '0;
   assign o_valid[1][3:2] = '0;
   assign o_last[1][3:2]  = '0;
   assign o_user[1][3:2]  = '0;

   csi2_vc_demux #(.VC_AMOUNT(4), .STRIP_CRC(1)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .pkt_tdata_i(in_data[0]), .pkt_tvalid_i(in_valid[0]), .pkt_tlast_i(in_last[0]),
      .pkt_tready_o(in_ready[0]),
      .vc_tdata_o(o_data[0]), .vc_tstrb_o(o_strb[0]), .vc_tvalid_o(o_valid[0]),
      .vc_tlast_o(o_last[0]), .vc_tuser_o(o_user[0]), .vc_tready_i(rdy[0]),
      .len_err_o(o_err[0]), .drop_o(o_drop[0]));

   csi2_vc_demux #(.VC_AMOUNT(2), .STRIP_CRC(0)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .pkt_tdata_i(in_data[1]), .pkt_tvalid_i(in_valid[1]), .pkt_tlast_i(in_last[1]),
      .pkt_tready_o(in_ready[1]),
      .vc_tdata_o(o_data[1][1:0]), .vc_tstrb_o(o_strb[1][1:0]), .vc_tvalid_o(o_valid[1][1:0]),
      .vc_tlast_o(o_last[1][1:0]), .vc_tuser_o(o_user[1][1:0]), .vc_tready_i(rdy[1][1:0]),
      .len_err_o(o_err[1]), .drop_o(o_drop[1]));

   int checks = 0;
   int errors = 0;

   // scoreboard entries are {tuser, tlast, tstrb, tdata}
   logic [37:0] exp_q[2][4][$];
   logic [37:0] obs_q[2][4][$];
   bit          sof[2][4];
   int          exp_err[2], obs_err[2], exp_drop[2], obs_drop[2], hold_viol[2];
   logic [1:0][3:0]       prev_hold = '0;
   logic [1:0][3:0][37:0] prev_word = '0;
   logic [37:0]           mon_cur;

   always @(posedge clk) begin
      #2;
      for (int d = 0; d < 2; d++)
         for (int v = 0; v < 4; v++)
            case (rdy_mode)
               0:       rdy[d][v] = 1'b1;
               1:       rdy[d][v] = ($urandom_range(0, 3) != 0);
               default: rdy[d][v] = rdy_force[d][v];
            endcase
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int v = 0; v < ((d == 0) ? 4 : 2); v++) begin
            mon_cur = {o_user[d][v], o_last[d][v], o_strb[d][v], o_data[d][v]};
            if (rst_n && prev_hold[d][v] && (!o_valid[d][v] || mon_cur !== prev_word[d][v]))
               hold_viol[d]++;
            if (o_valid[d][v] && rdy[d][v]) obs_q[d][v].push_back(mon_cur);
            prev_hold[d][v] = rst_n && o_valid[d][v] && !rdy[d][v];
            prev_word[d][v] = mon_cur;
         end
         if (o_err[d])  obs_err[d]++;
         if (o_drop[d]) obs_drop[d]++;
      end
   end

   task automatic clear_counts();
      for (int d = 0; d < 2; d++) begin
         exp_err[d] = 0; obs_err[d] = 0; exp_drop[d] = 0; obs_drop[d] = 0; hold_viol[d] = 0;
      end
   endtask

   function automatic bit drained();
      for (int d = 0; d < 2; d++)
         for (int v = 0; v < 4; v++)
            if (obs_q[d][v].size() < exp_q[d][v].size()) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int sb_mismatches();
      int bad = 0;
      for (int d = 0; d < 2; d++)
         for (int v = 0; v < 4; v++) begin
            if (obs_q[d][v].size() != exp_q[d][v].size()) begin
               bad++;
               $display("  dut%0d vc%0d: %0d words seen, %0d expected", d, v,
                        obs_q[d][v].size(), exp_q[d][v].size());
            end
            for (int i = 0; i < obs_q[d][v].size() && i < exp_q[d][v].size(); i++)
               if (obs_q[d][v][i] !== exp_q[d][v][i]) begin
                  bad++;
                  $display("  dut%0d vc%0d word %0d: got %h want %h", d, v, i,
                           obs_q[d][v][i], exp_q[d][v][i]);
               end
            obs_q[d][v].delete();
            exp_q[d][v].delete();
         end
      return bad;
   endfunction

   task automatic settle();
      int c = 0;
      while (!drained() && c < 3000) begin
         @(negedge clk);
         c++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic send_word(input int d, input logic [31:0] w, input logic l);
      bit done = 1'b0;
      int guard = 0;
      in_data[d] = w; in_valid[d] = 1'b1; in_last[d] = l;
      while (!done) begin
         done = in_ready[d];
         @(negedge clk);
         guard++;
         if (!done && guard > 2000) begin
            checks++; errors++;
            $display("FAIL input_handshake_timeout: dut%0d ready=%b, want 1", d, in_ready[d]);
            done = 1'b1;
         end
      end
      in_valid[d] = 1'b0; in_last[d] = 1'b0;
   endtask

   // Model: a long packet carries WC+2 bytes; P of them are forwarded as payload.
   task automatic send_pkt(input int d, input int vc, input int dt, input int wc, input int n);
      int amt   = (d == 0) ? 4 : 2;
      int strip = (d == 0) ? 1 : 0;
      int p, nwords, total, emit, bytes;
      logic [31:0] w[$];
      logic [31:0] hdr;
      hdr = {8'($urandom), 16'(wc), 2'(vc), 6'(dt)};
      if (dt < 16) begin
         if (vc < amt) begin
            if (dt == 0) sof[d][vc] = 1'b1;
            else if (dt == 1) sof[d][vc] = 1'b0;
         end
         send_word(d, hdr, 1'b1);
         return;
      end
      for (int i = 0; i < n; i++) w.push_back($urandom);
      p      = (strip != 0) ? wc : wc + 2;
      nwords = (p + 3) / 4;
      total  = (wc + 5) / 4;
      if (n == 0) exp_err[d]++;
      else if (vc >= amt) exp_drop[d]++;
      else begin
         emit = (n < nwords) ? n : nwords;
         for (int i = 0; i < emit; i++) begin
            bytes = p - 4 * i;
            if (bytes > 4) bytes = 4;
            exp_q[d][vc].push_back({1'(i == 0 && sof[d][vc]), 1'(i == emit - 1),
                                    4'((1 << bytes) - 1), w[i]});
         end
         if (emit > 0) sof[d][vc] = 1'b0;
         if (n < nwords || n > total) exp_err[d]++;
      end
      send_word(d, hdr, n == 0);
      for (int i = 0; i < n; i++) send_word(d, w[i], i == n - 1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rdy_mode = 0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL reset_tready: got %b want 11", in_ready); end
      checks++; if (o_valid !== 8'h00) begin errors++; $display("FAIL reset_tvalid: got %h want 00", o_valid); end
      checks++; if ({o_err, o_drop} !== 4'h0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {o_err, o_drop}); end
      checks++; if ({o_data[0], o_strb[0], o_last[0], o_user[0]} !== '0) begin
         errors++; $display("FAIL reset_payload_regs: got %h want 0", {o_data[0], o_strb[0], o_last[0], o_user[0]});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_strip_crc();
      int bad;
      clear_counts(); rdy_mode = 1;
      send_pkt(0, 1, 'h2B, 10, 3);
      send_pkt(0, 1, 'h2B, 8, 3);
      settle();
      checks++;
      if (obs_q[0][1].size() != 5) begin errors++; $display("FAIL strip_word_count: got %0d want 5", obs_q[0][1].size()); end
      else if (obs_q[0][1][2][36:32] !== 5'b1_0011) begin
         checks++; errors++; $display("FAIL strip_third_word: got last/strb %b want 10011", obs_q[0][1][2][36:32]);
      end
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL strip_scoreboard: got %0d mismatches want 0", bad); end
      checks++; if (obs_err[0] != exp_err[0]) begin errors++; $display("FAIL strip_len_err: got %0d want %0d", obs_err[0], exp_err[0]); end
   endtask

   task automatic test_no_strip();
      int bad;
      clear_counts(); rdy_mode = 1;
      send_pkt(1, 1, 'h2B, 10, 3);
      send_pkt(1, 0, 'h1E, 9, 3);
      settle();
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL nostrip_scoreboard: got %0d mismatches want 0", bad); end
      checks++; if (obs_err[1] != exp_err[1]) begin errors++; $display("FAIL nostrip_len_err: got %0d want %0d", obs_err[1], exp_err[1]); end
   endtask

   task automatic test_frame_start();
      int bad;
      clear_counts(); rdy_mode = 1;
      send_pkt(0, 2, 'h00, 0, 0);
      send_pkt(0, 2, 'h2B, 8, 3);
      send_pkt(0, 2, 'h2B, 8, 3);
      send_pkt(0, 3, 'h00, 0, 0);
      send_pkt(0, 3, 'h01, 0, 0);
      send_pkt(0, 3, 'h2B, 8, 3);
      send_pkt(0, 0, 'h00, 0, 0);
      send_pkt(0, 0, 'h00, 0, 0);
      send_pkt(0, 0, 'h2A, 12, 4);
      settle();
      checks++;
      if (obs_q[0][2].size() != 4) begin errors++; $display("FAIL fs_word_count: got %0d want 4", obs_q[0][2].size()); end
      else if ({obs_q[0][2][0][37], obs_q[0][2][1][37], obs_q[0][2][2][37]} !== 3'b100) begin
         checks++; errors++;
         $display("FAIL fs_tuser_pattern: got %b want 100", {obs_q[0][2][0][37], obs_q[0][2][1][37], obs_q[0][2][2][37]});
      end
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL fs_scoreboard: got %0d mismatches want 0", bad); end
   endtask

   task automatic test_backpressure();
      int bad;
      clear_counts(); rdy_mode = 2; rdy_force = '1; rdy_force[0][2] = 1'b0;
      send_pkt(0, 1, 'h2B, 4, 2);
      fork
         send_pkt(0, 2, 'h2B, 16, 5);
      join_none
      repeat (7) @(negedge clk);
      checks++; if (o_valid[0][2] !== 1'b1) begin errors++; $display("FAIL stall_vc2_valid: got %b want 1", o_valid[0][2]); end
      checks++; if (o_valid[0][1] !== 1'b0 || obs_q[0][1].size() != 1) begin
         errors++; $display("FAIL stall_vc1_flow: valid %b words %0d, want 0 and 1", o_valid[0][1], obs_q[0][1].size());
      end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_input_ready: got %b want 0", in_ready[0]); end
      rdy_force[0][2] = 1'b1;
      wait fork;
      settle();
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_scoreboard: got %0d mismatches want 0", bad); end
      checks++; if (hold_viol[0] != 0) begin errors++; $display("FAIL stall_hold: got %0d violations want 0", hold_viol[0]); end
   endtask

   task automatic test_drop();
      int bad;
      clear_counts(); rdy_mode = 1;
      send_pkt(1, 3, 'h2B, 8, 3);
      send_pkt(1, 2, 'h24, 5, 2);
      send_pkt(1, 0, 'h2B, 6, 2);
      settle();
      checks++; if (obs_drop[1] != 2) begin errors++; $display("FAIL drop_pulses: got %0d want 2", obs_drop[1]); end
      checks++; if (obs_err[1] != exp_err[1]) begin errors++; $display("FAIL drop_len_err: got %0d want %0d", obs_err[1], exp_err[1]); end
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL drop_scoreboard: got %0d mismatches want 0", bad); end
   endtask

   task automatic test_len_err();
      int bad;
      clear_counts(); rdy_mode = 1;
      send_pkt(0, 0, 'h2B, 20, 3);
      send_pkt(0, 1, 'h2B, 6, 2);
      settle();
      checks++; if (obs_err[0] != 1) begin errors++; $display("FAIL trunc_len_err: got %0d want 1", obs_err[0]); end
      send_pkt(0, 3, 'h2B, 4, 4);
      settle();
      checks++; if (obs_err[0] != 2) begin errors++; $display("FAIL overrun_len_err: got %0d want 2", obs_err[0]); end
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL lenerr_scoreboard: got %0d mismatches want 0", bad); end
   endtask

   task automatic test_random();
      int bad, d, vc, wc, n;
      clear_counts(); rdy_mode = 1;
      for (int k = 0; k < 120; k++) begin
         d  = k % 2;
         vc = $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) begin
            send_pkt(d, vc, $urandom_range(0, 3), 0, 0);
         end else begin
            wc = $urandom_range(0, 40);
            n  = (wc + 5) / 4 + $urandom_range(0, 4) - 2;
            if (n < 1) n = 1;
            send_pkt(d, vc, $urandom_range(16, 63), wc, n);
         end
      end
      settle();
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL random_scoreboard: got %0d mismatches want 0", bad); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (obs_err[i] != exp_err[i]) begin errors++; $display("FAIL random_len_err dut%0d: got %0d want %0d", i, obs_err[i], exp_err[i]); end
         checks++; if (obs_drop[i] != exp_drop[i]) begin errors++; $display("FAIL random_drop dut%0d: got %0d want %0d", i, obs_drop[i], exp_drop[i]); end
         checks++; if (hold_viol[i] != 0) begin errors++; $display("FAIL random_hold dut%0d: got %0d violations want 0", i, hold_viol[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      clear_counts(); rdy_mode = 2; rdy_force = '0;
      send_pkt(0, 0, 'h00, 0, 0);
      send_word(0, {8'h00, 16'd20, 2'd0, 6'h2B}, 1'b0);
      send_word(0, 32'hA5A5_0001, 1'b0);
      checks++; if (o_valid[0][0] !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b want 1", o_valid[0][0]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_valid !== 8'h00) begin errors++; $display("FAIL midreset_valid: got %h want 00", o_valid); end
      checks++; if (in_ready[0] !== 1'b1 || o_user[0] !== 4'h0) begin
         errors++; $display("FAIL midreset_ready_user: got %b/%h want 1/0", in_ready[0], o_user[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) for (int v = 0; v < 4; v++) sof[d][v] = 1'b0;
      bad = sb_mismatches();
      rdy_mode = 1;
      send_pkt(0, 0, 'h2B, 8, 3);
      settle();
      bad = sb_mismatches();
      checks++; if (bad != 0) begin errors++; $display("FAIL midreset_scoreboard: got %0d mismatches want 0", bad); end
      checks++; if (obs_err[0] != 0) begin errors++; $display("FAIL midreset_len_err: got %0d want 0", obs_err[0]); end
   endtask

   initial begin
      test_reset();
      test_strip_crc();
      test_no_strip();
      test_frame_start();
      test_backpressure();
      test_drop();
      test_len_err();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
